pipeline_wb_stage: RTL

PIPELINE_WB_STAGE -- requirements
Module: pipeline_wb_stage

---
 rtl/pipeline_wb_stage_pkg.sv | 22 ++
 rtl/pipeline_wb_stage_fwd.sv | 81 ++++++++
 rtl/pipeline_wb_stage.sv | 70 +++++++
 3 files changed

// File: rtl/pipeline_wb_stage_pkg.sv
// Shared CPU definitions used by the writeback stage: opcodes, control layout and the bypass entry.
package pipeline_wb_stage_pkg;
   localparam int WB_DATA_W  = 16;
   localparam int WB_REG_AW  = 3;
   localparam int WB_CTRL_W  = 22;
   localparam int OPC_W      = 3;
   localparam int RETIRED_W  = 16;

   localparam logic [OPC_W-1:0] OP_ALU = 3'b000;
   localparam logic [OPC_W-1:0] OP_LDR = 3'b011;

   // Control word: opcode in the top OPC_W bits, write-enable at bit REG_AW, writenum in [REG_AW-1:0].
   function automatic int we_bit(input int reg_aw);
      return reg_aw;
   endfunction

   typedef struct packed {
      logic                 vld;
      logic [WB_REG_AW-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } fwd_entry_t;
endpackage

// File: rtl/pipeline_wb_stage_fwd.sv
// vDFF flip-flop family and the retired-write history used for operand bypass.
module vDFFE #(
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         en,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);
   always_ff @(posedge clk)
      if (en) q <= d;
endmodule

module vDFFRE #(
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);
   always_ff @(posedge clk or posedge rst)
      if (rst)     q <= '0;
      else if (en) q <= d;
endmodule

module wb_fwd_history
   import pipeline_wb_stage_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter bit R0_ZERO = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  fwd_entry_t           cur,
   input  logic [WB_REG_AW-1:0] lk_addr,
   output logic                 hit,
   output logic [WB_DATA_W-1:0] data
);
   localparam int PW = WB_REG_AW + WB_DATA_W;

   logic [DEPTH-1:0]         vld_q;
   logic [DEPTH-1:0][PW-1:0] pay_q;
   fwd_entry_t               hist [DEPTH];

   // Only the valid bits are reset; payload is meaningless while its valid bit is low.
   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic          d_vld;
      logic [PW-1:0] d_pay;
      if (i == 0) begin : g_head
         assign d_vld = 1'b1;
         assign d_pay = {cur.addr, cur.data};
      end else begin : g_tail
         assign d_vld = vld_q[i-1];
         assign d_pay = pay_q[i-1];
      end
      vDFFRE #(.N(1))  u_vld (.clk, .rst, .en(cur.vld), .d(d_vld), .q(vld_q[i]));
      vDFFE  #(.N(PW)) u_pay (.clk, .en(cur.vld), .d(d_pay), .q(pay_q[i]));
      assign hist[i] = {vld_q[i], pay_q[i]};
   end

   // Walk oldest to newest so the newest match wins; the in-flight write beats all history.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int i = DEPTH-1; i >= 0; i--)
         if (hist[i].vld && hist[i].addr == lk_addr) begin
            hit  = 1'b1;
            data = hist[i].data;
         end
      if (cur.vld && cur.addr == lk_addr) begin
         hit  = 1'b1;
         data = cur.data;
      end
      if (R0_ZERO && lk_addr == '0) begin
         hit  = 1'b0;
         data = '0;
      end
   end
endmodule

// File: rtl/pipeline_wb_stage.sv
// Writeback stage: stage register, load/ALU writeback mux, delayed-branch hold, bypass and retire count.
module pipeline_wb_stage
   import pipeline_wb_stage_pkg::*;
#(
   parameter int               DATA_W    = WB_DATA_W,
   parameter int               REG_AW    = WB_REG_AW,
   parameter int               CTRL_W    = WB_CTRL_W,
   parameter logic [OPC_W-1:0] LDR_OP    = OP_LDR,
   parameter int               FWD_DEPTH = 2,
   parameter bit               R0_ZERO   = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 valid_in,
   input  logic [CTRL_W-1:0]    control_in,
   input  logic [DATA_W-1:0]    result_in,
   input  logic [DATA_W-1:0]    rdata_in,
   input  logic                 branch_req_in,
   input  logic [DATA_W-1:0]    branch_target_in,
   input  logic                 fetch_next_in,
   input  logic [REG_AW-1:0]    fwd_addr_in,
   output logic [DATA_W-1:0]    writeback_data_out,
   output logic [REG_AW-1:0]    writenum_out,
   output logic                 write_out,
   output logic                 branch_pending_out,
   output logic [DATA_W-1:0]    branch_target_out,
   output logic                 fwd_hit_out,
   output logic [DATA_W-1:0]    fwd_data_out,
   output logic [RETIRED_W-1:0] retired_out
);
   logic              valid_q;
   logic [CTRL_W-1:0] control_q;
   logic [DATA_W-1:0] result_q;

   vDFFRE #(.N(1))      u_valid (.clk, .rst, .en(1'b1), .d(valid_in & ~flush), .q(valid_q));
   vDFFRE #(.N(CTRL_W)) u_ctrl  (.clk, .rst, .en(1'b1), .d(control_in), .q(control_q));
   vDFFE  #(.N(DATA_W)) u_res   (.clk, .en(1'b1), .d(result_in), .q(result_q));

   assign write_out    = valid_q & control_q[we_bit(REG_AW)];
   assign writenum_out = control_q[REG_AW-1:0];
   // rdata_in is already registered by the RAM, so it lines up with this stage as-is.
   assign writeback_data_out = (control_q[CTRL_W-1 -: OPC_W] == LDR_OP) ? rdata_in : result_q;

   logic unused_ctrl;
   assign unused_ctrl = ^control_q[CTRL_W-OPC_W-1:REG_AW+1];

   // A held branch only reloads once fetch takes it, so flush cannot drop it mid-hold.
   logic br_ld;
   assign br_ld = fetch_next_in | ~branch_pending_out;
   vDFFRE #(.N(1))      u_br_pend (.clk, .rst, .en(br_ld), .d(branch_req_in & ~flush),
                                   .q(branch_pending_out));
   vDFFE  #(.N(DATA_W)) u_br_tgt  (.clk, .en(br_ld), .d(branch_target_in), .q(branch_target_out));

   logic ret_en;
   assign ret_en = write_out & ~(&retired_out);
   vDFFRE #(.N(RETIRED_W)) u_ret (.clk, .rst, .en(ret_en), .d(retired_out + 16'd1), .q(retired_out));

   fwd_entry_t cur;
   assign cur = '{vld: write_out, addr: writenum_out, data: writeback_data_out};

   wb_fwd_history #(.DEPTH(FWD_DEPTH), .R0_ZERO(R0_ZERO)) u_hist (
      .clk,
      .rst,
      .cur,
      .lk_addr (fwd_addr_in),
      .hit     (fwd_hit_out),
      .data    (fwd_data_out)
   );
endmodule
